// File: rtl/fetch_controller.sv
// fetch_controller: owns the program counter and sequences one instruction
// memory request at a time, presenting each fetched word downstream over a
// valid/ready handshake. Branch/jump redirects squash in-flight work safely.
//
// Build option: define FETCH_MISALIGN_TRAP_EN to trap on redirect targets with
// nonzero [1:0] (enters FAULT until Reset). Without it, target bits [1:0] are
// cleared before the PC is loaded and Fault is tied low.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset; accepts a redirect, then starts fetching
// REQ   | request outstanding at PC; capture response or retarget
// DRAIN | stale request outstanding; wait for it, then jump to pend_pc
// HOLD  | instruction held downstream until accepted or squashed
// FAULT | misaligned redirect trapped; frozen until Reset

module fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        RedirectValid,
    input  logic [1:0]  RedirectSel,
    input  logic [31:0] PCTarget,
    input  logic [31:0] ALUResult,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend_pc, pend_pc_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic [31:0] instr_pc_q, instr_pc_nxt;

    logic        redir_eff;
    logic [31:0] redir_tgt_raw;
    logic [31:0] redir_tgt;
    logic        redir_mis;
    logic [31:0] drain_tgt;
    logic        drain_mis;

    assign redir_eff     = RedirectValid && ((RedirectSel == 2'b01) || (RedirectSel == 2'b10));
    assign redir_tgt_raw = (RedirectSel == 2'b01) ? PCTarget : ALUResult;

    // A redirect landing in the same cycle as the draining response is the
    // most recent one, so it takes precedence over the stored pend_pc.
    assign drain_tgt = redir_eff ? redir_tgt : pend_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_tgt = redir_tgt_raw;
    assign redir_mis = |redir_tgt[1:0];
    assign drain_mis = |drain_tgt[1:0];
    assign Fault     = (state == S_FAULT);
`else
    assign redir_tgt = redir_tgt_raw & 32'hFFFF_FFFC;
    assign redir_mis = 1'b0;
    assign drain_mis = 1'b0;
    assign Fault     = 1'b0;
`endif

    assign imem_req   = (state == S_REQ) || (state == S_DRAIN);
    assign imem_addr  = pc;
    assign PC         = pc;
    assign PCPlus4    = pc + 32'd4;
    assign Instr      = instr_q;
    assign InstrPC    = instr_pc_q;
    // Masking with the live redirect keeps a wrong-path handshake from ever completing.
    assign InstrValid = (state == S_HOLD) && !redir_eff;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= S_IDLE;
            pc         <= RESET_VECTOR;
            pend_pc    <= 32'h0;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend_pc    <= pend_pc_nxt;
            instr_q    <= instr_nxt;
            instr_pc_q <= instr_pc_nxt;
        end
    end

    // Next-state and next-datapath decode.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        pend_pc_nxt  = pend_pc;
        instr_nxt    = instr_q;
        instr_pc_nxt = instr_pc_q;
        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                if (redir_eff) begin
                    pc_nxt = redir_tgt;
                    if (redir_mis) state_nxt = S_FAULT;
                end
            end
            S_REQ: begin
                if (imem_valid) begin
                    if (redir_eff) begin
                        pc_nxt = redir_tgt;
                        if (redir_mis) state_nxt = S_FAULT;
                    end else begin
                        instr_nxt    = imem_rdata;
                        instr_pc_nxt = pc;
                        state_nxt    = S_HOLD;
                    end
                end else if (redir_eff) begin
                    // Address must stay put until memory answers the old request.
                    pend_pc_nxt = redir_tgt;
                    state_nxt   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (redir_eff) pend_pc_nxt = redir_tgt;
                if (imem_valid) begin
                    pc_nxt    = drain_tgt;
                    state_nxt = drain_mis ? S_FAULT : S_REQ;
                end
            end
            S_HOLD: begin
                if (redir_eff) begin
                    pc_nxt    = redir_tgt;
                    state_nxt = redir_mis ? S_FAULT : S_REQ;
                end else if (InstrReady) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = S_REQ;
                end
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios followed by a randomized run against
// an architectural model (next presented address, memory contents by address).

module tb_fetch_controller;

    logic        CLK;
    logic        Reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        RedirectValid;
    logic [1:0]  RedirectSel;
    logic [31:0] PCTarget;
    logic [31:0] ALUResult;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Fault;

    int checks = 0;
    int errors = 0;

    int mem_cnt = 0;
    int cur_lat = 0;
    int mem_lat = 0;
    bit rand_mem = 0;

    fetch_controller #(.RESET_VECTOR(32'h00000000)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .RedirectValid(RedirectValid),
        .RedirectSel  (RedirectSel),
        .PCTarget     (PCTarget),
        .ALUResult    (ALUResult),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
        .Fault        (Fault)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory contents as a fixed function of address.
    function automatic logic [31:0] fmem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h12345678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responds a chosen number of cycles after each request starts.
    task automatic mem_drive();
        if (!imem_req) begin
            mem_cnt    = 0;
            imem_valid = 1'b0;
            imem_rdata = 32'hDEADBEEF;
        end else begin
            if (imem_valid) mem_cnt = 0;
            if (mem_cnt == 0) cur_lat = rand_mem ? int'($urandom_range(0, 3)) : mem_lat;
            imem_valid = (mem_cnt >= cur_lat);
            imem_rdata = imem_valid ? fmem(imem_addr) : 32'hDEADBEEF;
            mem_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        mem_drive();
        #1;
    endtask

    logic [31:0] exp_next;
    logic [31:0] held_pc;
    logic [31:0] tgt;
    logic [31:0] prev_addr;
    bit          shown;
    bit          eff;
    bit          prev_req;
    bit          prev_valid;
    int          presented;

    initial begin
        Reset         = 1'b1;
        imem_valid    = 1'b0;
        imem_rdata    = 32'h0;
        RedirectValid = 1'b0;
        RedirectSel   = 2'b00;
        PCTarget      = 32'h0;
        ALUResult     = 32'h0;
        InstrReady    = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_pc", PC, 32'h0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_ivalid", InstrValid, 1'b0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_instrpc", InstrPC, 32'h0);
        chk("rst_fault", Fault, 1'b0);

        // Startup and sequential fetch with zero-wait memory
        Reset = 1'b0;
        tick();
        chk("start_req", imem_req, 1'b1);
        chk("start_ivalid", InstrValid, 1'b0);
        tick();
        chk("seq0_valid", InstrValid, 1'b1);
        chk("seq0_pc", InstrPC, 32'h0);
        chk("seq0_instr", Instr, fmem(32'h0));
        tick();
        chk("seq_gap_valid", InstrValid, 1'b0);
        chk("seq_pc4", PC, 32'h4);
        tick();
        chk("seq1_valid", InstrValid, 1'b1);
        chk("seq1_pc", InstrPC, 32'h4);
        tick();
        tick();
        chk("seq2_valid", InstrValid, 1'b1);
        chk("seq2_pc", InstrPC, 32'h8);
        chk("seq_fault", Fault, 1'b0);

        // Backpressure in HOLD
        InstrReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_instrpc", InstrPC, 32'h8);
            chk("bp_instr", Instr, fmem(32'h8));
            chk("bp_pc", PC, 32'h8);
            chk("bp_req", imem_req, 1'b0);
        end
        InstrReady = 1'b1;
        tick();
        chk("bp_release_pc", PC, 32'hC);
        chk("bp_release_req", imem_req, 1'b1);

        // Redirects during DRAIN: last one wins
        Reset = 1'b1;
        tick();
        tick();
        Reset   = 1'b0;
        mem_lat = 0;
        tick();
        tick();
        tick();
        tick();
        chk("dr_pre_pc", InstrPC, 32'h4);
        mem_lat = 3;
        tick();
        chk("dr_req_addr", imem_addr, 32'h8);
        RedirectValid = 1'b1;
        RedirectSel   = 2'b01;
        PCTarget      = 32'h100;
        tick();
        chk("dr_hold_addr1", imem_addr, 32'h8);
        chk("dr_req1", imem_req, 1'b1);
        RedirectSel = 2'b10;
        ALUResult   = 32'h200;
        tick();
        RedirectValid = 1'b0;
        RedirectSel   = 2'b00;
        chk("dr_hold_addr2", imem_addr, 32'h8);
        tick();
        chk("dr_hold_addr3", imem_addr, 32'h8);
        chk("dr_mem_valid", imem_valid, 1'b1);
        mem_lat = 0;
        tick();
        chk("dr_new_addr", imem_addr, 32'h200);
        chk("dr_no_stale", InstrValid, 1'b0);
        tick();
        chk("dr_instrpc", InstrPC, 32'h200);
        chk("dr_instr", Instr, fmem(32'h200));

        // Redirect in HOLD with InstrReady=1 in the same cycle
        RedirectValid = 1'b1;
        RedirectSel   = 2'b01;
        PCTarget      = 32'h40;
        #1;
        chk("hold_redir_mask", InstrValid, 1'b0);
        tick();
        RedirectValid = 1'b0;
        RedirectSel   = 2'b00;
        chk("hold_redir_pc", PC, 32'h40);
        tick();
        chk("hold_redir_valid", InstrValid, 1'b1);
        chk("hold_redir_instrpc", InstrPC, 32'h40);

        // Wrap from the top of the address space
        RedirectValid = 1'b1;
        RedirectSel   = 2'b01;
        PCTarget      = 32'hFFFFFFFC;
        tick();
        RedirectValid = 1'b0;
        RedirectSel   = 2'b00;
        chk("wrap_pc", PC, 32'hFFFFFFFC);
        chk("wrap_pcplus4", PCPlus4, 32'h0);
        tick();
        chk("wrap_instrpc", InstrPC, 32'hFFFFFFFC);
        tick();
        chk("wrap_addr", imem_addr, 32'h0);

        // Misaligned JALR target
        RedirectValid = 1'b1;
        RedirectSel   = 2'b10;
        ALUResult     = 32'h102;
        tick();
`ifdef FETCH_MISALIGN_TRAP_EN
        PCTarget = 32'h300;
        for (int i = 0; i < 4; i++) begin
            RedirectSel = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("mis_fault", Fault, 1'b1);
            chk("mis_pc", PC, 32'h102);
            chk("mis_req", imem_req, 1'b0);
            chk("mis_ivalid", InstrValid, 1'b0);
            tick();
        end
        RedirectValid = 1'b0;
        RedirectSel   = 2'b00;
        Reset         = 1'b1;
        tick();
        chk("mis_reset_fault", Fault, 1'b0);
`else
        RedirectValid = 1'b0;
        RedirectSel   = 2'b00;
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_fault", Fault, 1'b0);
        chk("mis_req", imem_req, 1'b1);
`endif

        // Randomized run against the architectural model
        Reset    = 1'b1;
        rand_mem = 1'b1;
        tick();
        tick();
        Reset      = 1'b0;
        exp_next   = 32'h0;
        shown      = 1'b0;
        held_pc    = 32'h0;
        prev_req   = 1'b0;
        prev_valid = 1'b0;
        prev_addr  = 32'h0;
        presented  = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            chk("rnd_fault", Fault, 1'b0);
            if (prev_req && !prev_valid) begin
                chk("rnd_req_held", imem_req, 1'b1);
                chk("rnd_addr_stable", imem_addr, prev_addr);
            end
            RedirectValid = ($urandom_range(0, 5) == 0);
            RedirectSel   = 2'($urandom_range(0, 3));
`ifdef FETCH_MISALIGN_TRAP_EN
            PCTarget  = $urandom & 32'hFFFFFFFC;
            ALUResult = $urandom & 32'hFFFFFFFC;
`else
            PCTarget  = $urandom;
            ALUResult = $urandom;
`endif
            InstrReady = ($urandom_range(0, 3) != 0);
            #1;
            eff = RedirectValid && (RedirectSel == 2'b01 || RedirectSel == 2'b10);
            tgt = ((RedirectSel == 2'b01) ? PCTarget : ALUResult) & 32'hFFFFFFFC;
            if (eff) chk("rnd_redir_mask", InstrValid, 1'b0);
            if (InstrValid) begin
                if (!shown) begin
                    chk("rnd_next_pc", InstrPC, exp_next);
                    held_pc = InstrPC;
                    shown   = 1'b1;
                    presented++;
                end else begin
                    chk("rnd_held_pc", InstrPC, held_pc);
                end
                chk("rnd_instr", Instr, fmem(InstrPC));
            end
            if (eff) begin
                exp_next = tgt;
                shown    = 1'b0;
            end else if (InstrValid && InstrReady) begin
                exp_next = InstrPC + 32'd4;
                shown    = 1'b0;
            end
            prev_req   = imem_req;
            prev_valid = imem_valid;
            prev_addr  = imem_addr;
        end
        chk("rnd_progress", 32'(presented > 200), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
